// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_pkg
// Description : Shared types and default parameter values for the
//               instruction-fetch controller (if_fetch_ctrl) and its
//               output buffer (if_skid_buf).
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

  // Fetch sequencer states. The encoding is explicit so that the state
  // register has a stable width in every tool.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // first cycle after reset release
    REQ  = 2'd1,  // presenting a request to instruction memory
    WAIT = 2'd2,  // request accepted, waiting for the response
    DROP = 2'd3   // request accepted, response will be discarded
  } fetch_state_t;

  localparam int          ADDR_W_DEFAULT   = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_INC_DEFAULT   = 4;

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : if_skid_buf
// Description : Two-entry FIFO of {pc, inst} (head + skid). The head entry
//               is what the consumer sees; the skid entry catches a push that
//               arrives while the head is full and not being popped.
// Ports       : clk, reset (async, active-low)
//               push, push_pc, push_inst : write one entry
//               pop        : consumer takes the head (ignored when empty)
//               flush      : discard both entries (wins over push/pop)
//               head_pc, head_inst, head_valid : head entry
//               skid_full  : skid entry occupied
// Revision    : 1.0 - initial release
// ============================================================================
module if_skid_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_pc,
  input  logic [W-1:0] push_inst,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] head_pc,
  output logic [W-1:0] head_inst,
  output logic         head_valid,
  output logic         skid_full
);

  logic [W-1:0] skid_pc;
  logic [W-1:0] skid_inst;
  logic         pop_eff;

  assign pop_eff   = pop & head_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_pc    <= '0;
      head_inst  <= '0;
      head_valid <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      skid_full  <= 1'b0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_full  <= 1'b0;
    end else if (pop_eff) begin
      if (skid_full) begin
        // Skid advances to head; a simultaneous push refills the skid so
        // FIFO order is preserved.
        head_pc    <= skid_pc;
        head_inst  <= skid_inst;
        head_valid <= 1'b1;
        skid_full  <= push;
        if (push) begin
          skid_pc   <= push_pc;
          skid_inst <= push_inst;
        end
      end else begin
        // Head is leaving this cycle, so a push can take its place directly.
        head_valid <= push;
        if (push) begin
          head_pc   <= push_pc;
          head_inst <= push_inst;
        end
      end
    end else if (push) begin
      if (!head_valid) begin
        head_pc    <= push_pc;
        head_inst  <= push_inst;
        head_valid <= 1'b1;
      end else begin
        skid_pc    <= push_pc;
        skid_inst  <= push_inst;
        skid_full  <= 1'b1;
      end
    end
  end

endmodule : if_skid_buf
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction fetch sequencer. Owns the fetch PC, issues at
//               most one outstanding instruction-memory request, applies
//               branch redirects (which also flush fetched instructions) and
//               buffers up to two responses while ID is stalled.
// Ports       : clk, reset (async, active-low)
//               redirect_valid/redirect_pc : branch/jump redirect + flush
//               stall                      : ID cannot accept this cycle
//               imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata : memory
//               if_valid/if_pc/if_inst     : instruction to IF/ID register
//               fetch_busy                 : request outstanding
//               perf_fetch_cnt, perf_redirect_cnt (only with FETCH_PERF_EN)
// Options     : FETCH_PERF_EN - adds consume and redirect event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int              PC_INC   = PC_INC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_inst,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_redirect_cnt,
`endif
  output logic              fetch_busy
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              skid_full;
  logic              accept;
  logic              push;

  // Issue is held off while the skid is occupied: with both entries full
  // there would be nowhere to put the response.
  assign imem_req   = (state == REQ) && !skid_full;
  assign imem_addr  = fetch_pc;
  assign accept     = imem_req & imem_gnt;
  assign push       = (state == WAIT) & imem_rvalid & ~redirect_valid;
  assign fetch_busy = (state == WAIT) || (state == DROP);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (accept) state_next = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid)         state_next = REQ;
        else if (redirect_valid) state_next = DROP;
      end
      DROP: begin
        if (imem_rvalid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else begin
      state <= state_next;
      // A redirect always retargets fetch, whatever state we are in.
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
        req_pc   <= fetch_pc;
      end
    end
  end

  if_skid_buf #(
    .W (ADDR_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (req_pc),
    .push_inst  (imem_rdata),
    .pop        (~stall),
    .flush      (redirect_valid),
    .head_pc    (if_pc),
    .head_inst  (if_inst),
    .head_valid (if_valid),
    .skid_full  (skid_full)
  );

`ifdef FETCH_PERF_EN
  // A head presented in a flush cycle is squashed, so it is not a consume.
  logic consume;
  assign consume = if_valid & ~stall & ~redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (consume)        perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule : if_fetch_ctrl
`default_nettype wire
